// File: rtl/hclk_edge_detector.sv
// HCLK edge detector: samples the asynchronous bus clock HCLK through a
// SYNC_STAGES-deep synchronizer in the clk domain and emits one-clk-cycle
// pulses on each synchronized rising (HCLK_rise) or falling (HCLK_fall) edge.
// HCLK is treated purely as data; it never clocks any flop.
module hclk_edge_detector #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic HCLK,
    output logic HCLK_rise,
    output logic HCLK_fall
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("hclk_edge_detector: SYNC_STAGES must be in the range 2..4");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   sync_level;

    // Next state: shift HCLK into the synchronizer, remember the last synchronized level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], HCLK};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // State registers; asynchronous clear so outputs drop as soon as reset asserts.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Edge decode from flops only, so there is no combinational path from HCLK.
    always_comb begin
        sync_level = sync_q[SYNC_STAGES-1];
        HCLK_rise  = sync_level & ~prev_q;
        HCLK_fall  = ~sync_level & prev_q;
    end

endmodule

// File: tb/tb_hclk_edge_detector.sv
// Self-checking bench for hclk_edge_detector with SYNC_STAGES=2 and =3.
// The reference model records the HCLK level seen at every clk edge and
// derives each DUT's expected pulses from the levels SYNC_STAGES-1 and
// SYNC_STAGES edges ago, discarding samples taken before the last reset.
module tb_hclk_edge_detector;

    localparam int MAXE = 4096;

    logic clk;
    logic n_rst;
    logic HCLK;
    logic r2, f2, r3, f3;

    int errors = 0;
    int checks = 0;

    hclk_edge_detector #(.SYNC_STAGES(2)) dut2 (
        .clk      (clk),
        .n_rst    (n_rst),
        .HCLK     (HCLK),
        .HCLK_rise(r2),
        .HCLK_fall(f2)
    );

    hclk_edge_detector #(.SYNC_STAGES(3)) dut3 (
        .clk      (clk),
        .n_rst    (n_rst),
        .HCLK     (HCLK),
        .HCLK_rise(r3),
        .HCLK_fall(f3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: sample log indexed by clk edge number.
    bit samp [0:MAXE];
    int n        = 0;
    int last_rst = 0;

    always @(posedge clk) begin
        n = n + 1;
        if (n <= MAXE) samp[n] = (n_rst === 1'b1) ? HCLK : 1'b0;
    end

    always @(negedge n_rst) last_rst = n;

    function automatic bit level(input int m);
        if (m <= last_rst || m < 1 || m > MAXE) return 1'b0;
        return samp[m];
    endfunction

    // Expected {rise2, fall2, rise3, fall3} after the most recent edge.
    function automatic logic [3:0] exp_out();
        bit s2, p2, s3, p3;
        s2 = level(n - 1);
        p2 = level(n - 2);
        s3 = level(n - 2);
        p3 = level(n - 3);
        return {s2 & ~p2, ~s2 & p2, s3 & ~p3, ~s3 & p3};
    endfunction

    task automatic test_reset();
        n_rst = 1'b0;
        HCLK  = 1'b0;
        #1;
        checks++;
        if ({r2, f2, r3, f3} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_initial got=%b expected=0000", {r2, f2, r3, f3});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({r2, f2, r3, f3} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_held cyc=%0d got=%b expected=0000", i, {r2, f2, r3, f3});
            end
            #1 HCLK = ~HCLK;
        end
        HCLK = 1'b0;
        @(posedge clk); #2 n_rst = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            checks++;
            if ({r2, f2, r3, f3} !== 4'b0000 || exp_out() !== 4'b0000) begin
                errors++;
                $display("FAIL release_low e=%0d got=%b model=%b expected=0000", e, {r2, f2, r3, f3}, exp_out());
            end
        end
    endtask

    task automatic test_release_high();
        #1 n_rst = 1'b0;
        HCLK = 1'b1;
        @(posedge clk); #2 n_rst = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            checks++;
            if ({r2, f2, r3, f3} !== {e == 2, 1'b0, e == 3, 1'b0}) begin
                errors++;
                $display("FAIL release_high e=%0d got=%b expected=%b", e, {r2, f2, r3, f3},
                         {e == 2, 1'b0, e == 3, 1'b0});
            end
            checks++;
            if ({r2, f2, r3, f3} !== exp_out()) begin
                errors++;
                $display("FAIL release_high_model e=%0d got=%b expected=%b", e, {r2, f2, r3, f3}, exp_out());
            end
        end
    endtask

    // HCLK changes 2 ns after an edge; SYNC_STAGES=2 pulses at the 2nd following edge, =3 at the 3rd.
    task automatic test_latency();
        for (int t = 0; t < 2; t++) begin
            logic lvl;
            logic [3:0] want;
            lvl = (t == 0) ? 1'b0 : 1'b1;
            #1 HCLK = lvl;
            for (int e = 1; e <= 5; e++) begin
                @(posedge clk); #1;
                want = lvl ? {e == 2, 1'b0, e == 3, 1'b0} : {1'b0, e == 2, 1'b0, e == 3};
                checks++;
                if ({r2, f2, r3, f3} !== want) begin
                    errors++;
                    $display("FAIL latency lvl=%0b e=%0d got=%b expected=%b", lvl, e, {r2, f2, r3, f3}, want);
                end
            end
        end
        #1 HCLK = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_stable();
        int rises = 0;
        int falls = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({r2, f2, r3, f3} !== exp_out()) begin
                errors++;
                $display("FAIL stable cyc=%0d got=%b expected=%b", c, {r2, f2, r3, f3}, exp_out());
            end
            rises += int'(r2);
            falls += int'(f2);
            if (c == 49) #1 HCLK = 1'b1;
        end
        checks++;
        if (rises != 1 || falls != 0) begin
            errors++;
            $display("FAIL stable_count rises=%0d falls=%0d expected rises=1 falls=0", rises, falls);
        end
        #1 HCLK = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    // 10 clk per HCLK period, 50% duty, 10 periods.
    task automatic test_free_running();
        int rises = 0;
        int falls = 0;
        int last_rise = -1;
        int bad_gap = 0;
        int overlap = 0;
        for (int c = 0; c < 106; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({r2, f2, r3, f3} !== exp_out()) begin
                errors++;
                $display("FAIL free_run cyc=%0d got=%b expected=%b", c, {r2, f2, r3, f3}, exp_out());
            end
            if (r2 && f2) overlap++;
            if (r2) begin
                rises++;
                last_rise = c;
            end
            if (f2) begin
                falls++;
                if (last_rise >= 0 && c - last_rise != 5) bad_gap++;
            end
            if (c < 100 && (c % 5) == 4) #1 HCLK = ~HCLK;
        end
        checks++;
        if (rises != 10 || falls != 10) begin
            errors++;
            $display("FAIL free_run_count rises=%0d falls=%0d expected 10/10", rises, falls);
        end
        checks++;
        if (bad_gap != 0 || overlap != 0) begin
            errors++;
            $display("FAIL free_run_spacing bad_gaps=%0d overlaps=%0d expected 0/0", bad_gap, overlap);
        end
    endtask

    task automatic test_random();
        int left;
        left = int'($urandom_range(1, 8));
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({r2, f2, r3, f3} !== exp_out()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b expected=%b", c, {r2, f2, r3, f3}, exp_out());
            end
            checks++;
            if ((r2 && f2) || (r3 && f3)) begin
                errors++;
                $display("FAIL random_exclusive cyc=%0d got=%b expected no rise+fall", c, {r2, f2, r3, f3});
            end
            left--;
            if (left == 0) begin
                #1 HCLK = ~HCLK;
                left = int'($urandom_range(1, 8));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        #1 HCLK = 1'b1;
        repeat (6) @(posedge clk);
        #2 HCLK = 1'b0;
        for (int w = 0; w < 10 && !found; w++) begin
            @(posedge clk); #1;
            if (f2) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid_wait got=no fall pulse expected=fall within 10 cycles");
        end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if ({r2, f2, r3, f3} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_drop got=%b expected=0000", {r2, f2, r3, f3});
        end
        repeat (3) @(posedge clk);
        #2 n_rst = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            checks++;
            if ({r2, f2, r3, f3} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_release e=%0d got=%b expected=0000", e, {r2, f2, r3, f3});
            end
        end
        #1 HCLK = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1;
            checks++;
            if ({r2, f2, r3, f3} !== {e == 2, 1'b0, e == 3, 1'b0}) begin
                errors++;
                $display("FAIL reset_mid_next_rise e=%0d got=%b expected=%b", e, {r2, f2, r3, f3},
                         {e == 2, 1'b0, e == 3, 1'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_release_high();
        test_latency();
        test_stable();
        test_free_running();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
